// File: rtl/lc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc_mem_arbiter
//
// Round-robin arbiter and read sequencer in front of the single read port of
// the lifecycle-token ROM (lc_memory). NUM_REQ requesters compete for the
// port; the winner gets exactly one read, out-of-range addresses are
// answered locally with an error and never reach the ROM, and the response
// is returned as a one-cycle pulse on the winner's rsp_valid bit only.
//
// Transaction shape (one outstanding read at a time):
//   IDLE  -> ISSUE : winner picked, gnt and mem_rd_en registered
//   ISSUE -> WAIT  : mem_rd_en dropped after one cycle
//   WAIT  -> RESP  : ROM valid seen, data captured into rsp_data
//   RESP  -> IDLE  : rsp_valid pulse ends, gnt released
// An out-of-range address goes ISSUE -> RESP directly with rsp_err=1.
//
// Optional build macro LC_ARB_TIMEOUT_EN: bounds the WAIT state to TIMEOUT
// cycles and returns an error response if the ROM never answers. Without
// the macro the sequencer waits for mem_valid indefinitely.
// ---------------------------------------------------------------------------
module lc_mem_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 256,
    parameter  int LENGTH  = 6,
    parameter  int TIMEOUT = 8,
    localparam int AW      = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [WIDTH-1:0]      mem_rdData,
    input  logic                  mem_valid
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Registered state and outputs
    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_data;
    logic                 r_rsp_err;
    logic                 r_rd_en;
    logic [AW-1:0]        r_mem_addr;
    logic                 r_oor;

    // Arbitration results for the current cycle
    logic                 w_any;
    logic                 w_found;
    logic [PW:0]          w_cand;
    logic [PW-1:0]        w_win_idx;
    logic [AW-1:0]        w_win_addr;
    logic                 w_win_oor;
    logic [PW-1:0]        w_next_ptr;
    logic [NUM_REQ-1:0]   w_win_onehot;

`ifdef LC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]        r_wait_cnt;
    logic                 w_wait_expired;

    assign w_wait_expired = (r_wait_cnt == CW'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the WAIT bound is compiled in.
    logic                 w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
`endif

    // Round-robin search from r_ptr upward with wrap-around; first requester found wins
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        w_any        = |req;
        w_found      = 1'b0;
        w_cand       = '0;
        w_win_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_cand >= (PW + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (PW + 1)'(NUM_REQ);
            end
            if (!w_found && req[w_cand[PW-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand[PW-1:0];
            end
        end
        w_win_addr   = req_addr[w_win_idx*AW +: AW];
        w_win_oor    = (int'(w_win_addr) >= LENGTH);
        w_next_ptr   = (w_win_idx == PW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        w_win_onehot = NUM_REQ'(1) << w_win_idx;
    end

    // Transaction FSM: arbitration, ROM handshake, response pulse; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_mem_addr  <= '0;
            r_oor       <= 1'b0;
`ifdef LC_ARB_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples the pre-edge values of the others.
            case (r_state)
                S_IDLE: begin
                    // Late ROM valids (e.g. after a timeout) are ignored here.
                    if (w_any) begin
                        r_gnt   <= w_win_onehot;
                        r_ptr   <= w_next_ptr;
                        r_oor   <= w_win_oor;
                        // The read strobe is raised together with the grant so
                        // the ROM answers two edges after arbitration.
                        r_rd_en <= !w_win_oor;
                        if (!w_win_oor) begin
                            r_mem_addr <= w_win_addr;
                        end
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_rd_en <= 1'b0;
                    if (r_oor) begin
                        // Rejected locally: the ROM never sees this address.
                        r_rsp_valid <= r_gnt;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
`ifdef LC_ARB_TIMEOUT_EN
                        r_wait_cnt  <= '0;
`endif
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_valid) begin
                        r_rsp_valid <= r_gnt;
                        r_rsp_data  <= mem_rdData;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end
`ifdef LC_ARB_TIMEOUT_EN
                    else if (w_wait_expired) begin
                        r_rsp_valid <= r_gnt;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    // Pulse ends and the grant is released on the way back to IDLE.
                    r_rsp_valid <= '0;
                    r_rsp_data  <= '0;
                    r_rsp_err   <= 1'b0;
                    r_gnt       <= '0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_lc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc_mem_arbiter
//
// Bench for lc_mem_arbiter with a behavioural ROM (valid one cycle after
// rd_en). Expected responses are queued when requests are raised and
// compared when a rsp_valid pulse appears. Build with LC_ARB_TIMEOUT_EN to
// exercise the WAIT timeout instead of the indefinite wait.
// ---------------------------------------------------------------------------
module tb_lc_mem_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 256;
    localparam int LENGTH  = 6;
    localparam int TIMEOUT = 8;
    localparam int AW      = $clog2(LENGTH);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_addr;
    logic [WIDTH-1:0]      mem_rdData;
    logic                  mem_valid;

    lc_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .LENGTH  (LENGTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdData (mem_rdData),
        .mem_valid  (mem_valid)
    );

    always #5 clk = ~clk;

    // ROM model: registered read, valid the cycle after rd_en
    logic [WIDTH-1:0] rom [LENGTH];
    logic             no_valid;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid  <= 1'b0;
            mem_rdData <= '0;
        end else begin
            mem_valid  <= mem_rd_en && !no_valid;
            mem_rdData <= (mem_rd_en && !no_valid) ? rom[mem_addr] : '0;
        end
    end

    // Scoreboard
    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    typedef struct {
        int idx;
        int cyc;
    } gnt_ev_t;

    exp_t            sb[$];
    gnt_ev_t         gnt_log[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc      = 0;
    int              exp_ptr  = 0;
    logic [NUM_REQ-1:0] hold;
    logic [NUM_REQ-1:0] prev_gnt = '0;
    exp_t            mon_e;

    task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: invariants every cycle, scoreboard pop on each pulse
    always @(negedge clk) begin
        check("gnt_onehot0", WIDTH'($onehot0(gnt)), 1);
        check("rsp_onehot0", WIDTH'($onehot0(rsp_valid)), 1);
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", WIDTH'(rsp_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_valid", WIDTH'(rsp_valid), WIDTH'(1) << mon_e.idx);
                check("rsp_data", rsp_data, mon_e.data);
                check("rsp_err", WIDTH'(rsp_err), WIDTH'(mon_e.err));
                check("rsp_gnt", WIDTH'(gnt), WIDTH'(rsp_valid));
            end
        end else begin
            check("rsp_data_idle", rsp_data, 0);
        end
        if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) gnt_log.push_back('{idx: i, cyc: cyc});
            end
        end
        prev_gnt = gnt;
    end

    // Reference round-robin pick from the bench's own pointer
    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (exp_ptr + k) % NUM_REQ;
            if (mask[i]) begin
                exp_ptr = (i + 1) % NUM_REQ;
                return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    task automatic push_exp(input int i);
        exp_t e;
        logic [AW-1:0] a;
        a = addr_of(i);
        e.idx  = i;
        e.err  = (int'(a) >= LENGTH);
        e.data = e.err ? '0 : rom[a];
        sb.push_back(e);
    endtask

    task automatic push_all(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] m;
        int w;
        m = mask;
        while (m != '0) begin
            w = rr_pick(m);
            push_exp(w);
            m[w] = 1'b0;
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        hold     = '0;
        no_valid = 1'b0;
        exp_ptr  = 0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Run until the scoreboard empties, releasing requesters once answered
    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid[i] && !hold[i]) req[i] = 1'b0;
            end
            c++;
        end
        check({tag, "_pending"}, WIDTH'(sb.size()), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = {32'h0f1e2d3c, {6{32'h11112222}}, 32'h4b5a6978};
        rom[1] = {32'h33a344a3, {6{32'h5a5a1111}}, 32'hea56a24a};
        rom[2] = {32'h988b6a57, {6{32'h76543210}}, 32'h0badf00d};
        rom[3] = {32'h13579bdf, {6{32'h2468ace0}}, 32'hfedcba98};
        rom[4] = {32'hdeadbeef, {6{32'hcafebabe}}, 32'h8badf00d};
        rom[5] = {32'hc3e0fed6, {6{32'h0a0b0c0d}}, 32'h1234abcd};
        req      = '0;
        req_addr = '0;
        hold     = '0;
        no_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("reset_gnt", WIDTH'(gnt), 0);
        check("reset_rd_en", WIDTH'(mem_rd_en), 0);
        check("reset_addr", WIDTH'(mem_addr), 0);
        check("reset_rsp_err", WIDTH'(rsp_err), 0);
        do_reset();

        // Single requester; address change after grant must be ignored
        set_addr(1, 3'd1);
        req = 4'b0010;
        push_all(req);
        tick();
        check("single_gnt", WIDTH'(gnt), 4'b0010);
        check("single_rd_en", WIDTH'(mem_rd_en), 1);
        check("single_mem_addr", WIDTH'(mem_addr), 1);
        set_addr(1, 3'd4);
        tick();
        check("single_rd_en_once", WIDTH'(mem_rd_en), 0);
        tick();
        check("single_rsp_time", WIDTH'(rsp_valid), 4'b0010);
        req = '0;
        tick();
        check("single_gnt_clear", WIDTH'(gnt), 0);
        check("single_sb_empty", WIDTH'(sb.size()), 0);

        // Contention: requesters 0 and 2, grants four cycles apart
        do_reset();
        gnt_log.delete();
        set_addr(0, 3'd2);
        set_addr(2, 3'd5);
        req = 4'b0101;
        push_all(req);
        drain("contention", 20);
        check("cont_ngnt", WIDTH'(gnt_log.size()), 2);
        if (gnt_log.size() >= 2) begin
            check("cont_first", WIDTH'(gnt_log[0].idx), 0);
            check("cont_second", WIDTH'(gnt_log[1].idx), 2);
            check("cont_spacing", WIDTH'(gnt_log[1].cyc - gnt_log[0].cyc), 4);
        end

        // Fairness: 0 and 3 held high for eight transactions
        do_reset();
        gnt_log.delete();
        set_addr(0, 3'd0);
        set_addr(3, 3'd4);
        req  = 4'b1001;
        hold = 4'b1001;
        for (int t = 0; t < 8; t++) push_exp(rr_pick(4'b1001));
        drain("fairness", 60);
        req  = '0;
        hold = '0;
        tick();
        tick();
        check("fair_ngnt", WIDTH'(gnt_log.size()), 8);
        for (int i = 1; i < gnt_log.size(); i++) begin
            check("fair_spacing", WIDTH'(gnt_log[i].cyc - gnt_log[i-1].cyc), 4);
        end

        // Out-of-range address: answered locally with error, ROM untouched
        do_reset();
        set_addr(2, 3'd7);
        req = 4'b0100;
        push_all(req);
        tick();
        check("oor_gnt", WIDTH'(gnt), 4'b0100);
        check("oor_rd_en_a", WIDTH'(mem_rd_en), 0);
        tick();
        check("oor_rsp_time", WIDTH'(rsp_valid), 4'b0100);
        check("oor_rd_en_b", WIDTH'(mem_rd_en), 0);
        req = '0;
        tick();
        check("oor_gnt_clear", WIDTH'(gnt), 0);
        check("oor_sb_empty", WIDTH'(sb.size()), 0);

        // Reset while waiting on the ROM: abort without a response pulse
        do_reset();
        set_addr(1, 3'd3);
        req = 4'b0010;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rstwait_gnt", WIDTH'(gnt), 0);
        check("rstwait_rsp", WIDTH'(rsp_valid), 0);
        check("rstwait_rd_en", WIDTH'(mem_rd_en), 0);
        check("rstwait_data", rsp_data, 0);
        req = '0;
        exp_ptr = 0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 3'(i));
        req = 4'b1111;
        push_all(req);
        tick();
        check("rstwait_prio", WIDTH'(gnt), 4'b0001);
        drain("rerequest", 40);

`ifdef LC_ARB_TIMEOUT_EN
        // ROM never answers: error response eight cycles after WAIT entry
        do_reset();
        no_valid = 1'b1;
        set_addr(3, 3'd2);
        req = 4'b1000;
        push_exp(rr_pick(req));
        tick();
        tick();
        begin
            int c;
            c = 0;
            while (rsp_valid == '0 && c < 20) begin
                tick();
                c++;
            end
            check("timeout_latency", WIDTH'(c), 8);
        end
        req = '0;
        drain("timeout", 10);
`else
        // ROM never answers: the grant is held with no response
        do_reset();
        no_valid = 1'b1;
        set_addr(3, 3'd2);
        req = 4'b1000;
        repeat (20) tick();
        check("wait_hold_gnt", WIDTH'(gnt), 4'b1000);
        check("wait_hold_rsp", WIDTH'(rsp_valid), 0);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc_mem_arbiter.md
Name: lc_mem_arbiter

Overview:
Round-robin arbiter and read sequencer for the lifecycle-token ROM (lc_memory).
- Shares the ROM's single read port among NUM_REQ requesters (fuse controller, debug unlock, boot FSM, ...).
- Each requester gets one read per grant.
- Out-of-range addresses are rejected before they reach the memory.
- Each response is returned with a one-cycle pulse to the granted requester only.

Parameters:
NUM_REQ, 4, number of requesters (>=2).
WIDTH, 256, token width; must match the ROM.
LENGTH, 6, number of ROM entries; AW = $clog2(LENGTH) is a localparam.
TIMEOUT, 8, WAIT-state cycle limit; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous active-low reset (rst=0 resets)
req  in  NUM_REQ  per-requester read request, level
req_addr  in  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester
rsp_data  out  WIDTH  response token; valid only while a rsp_valid bit is high
rsp_err  out  1  error qualifier; valid with rsp_valid
mem_rd_en  out  1  to ROM rd_en
mem_addr  out  AW  to ROM addr
mem_rdData  in  WIDTH  from ROM rdData
mem_valid  in  1  from ROM valid

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; gnt, rsp_valid, rsp_err, mem_rd_en, mem_addr = 0; rsp_data=0; captured data=0; RR pointer=0 (requester 0 has highest priority). All outputs are registered.
- The ROM returns data with valid=1 on the cycle after rd_en=1, and drives valid=0 when rd_en=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req is high:
  - Select the winner round-robin, searching from index (ptr) upward with wrap-around.
  - Register gnt, latch that requester's addr, go to ISSUE.
  - Update ptr = winner+1 mod NUM_REQ.
  - mem_valid is ignored in IDLE.
- ISSUE, addr < LENGTH: mem_rd_en=1 for exactly one cycle, mem_addr=latched addr; go to WAIT.
- ISSUE, addr >= LENGTH: mem_rd_en stays 0; capture data=0, err=1; go to RESP.
- WAIT: on mem_valid=1, capture mem_rdData with err=0 and go to RESP. Without the optional feature, WAIT holds indefinitely until mem_valid=1.
- RESP:
  - rsp_valid[winner]=1 for one cycle; rsp_data and rsp_err hold the captured values.
  - Next state is IDLE, and gnt clears on that transition.
  - rsp_data returns to 0 when rsp_valid is low.
- Timing, with req sampled high at edge N in IDLE:
  - N+1: gnt and mem_rd_en.
  - N+2: ROM valid; data captured.
  - N+3: rsp_valid.
  - N+4: IDLE, grant cleared.
  - New arbitration at edge N+4 at the earliest, giving a throughput of 1 read per 4 cycles.
- Requester rules:
  - req and req_addr must stay stable until rsp_valid.
  - Address is latched at grant; changes after grant are ignored.
  - If req drops mid-transaction, the transaction still completes and the response is still pulsed.
  - A requester holding req high after its response is re-arbitrated and loses to any other pending requester.
- Only one transaction is outstanding at a time. gnt and rsp_valid are never multi-hot.
- Reset mid-transaction: immediate return to reset values; no rsp_valid pulse for the aborted transaction.

Optional Feature:
Macro: LC_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on WAIT entry.
  - If mem_valid has not been seen after TIMEOUT cycles in WAIT, go to RESP with rsp_data=0 and rsp_err=1.
  - A mem_valid arriving after the timeout is ignored in IDLE.
- Undefined: no counter logic; WAIT waits for mem_valid forever.

Test Plan:
- Single requester: req[1]=1, addr=1 -> gnt=4'b0010 at N+1, mem_rd_en one cycle; rsp_valid=4'b0010 at N+3; rsp_data=256'h33a344a3...ea56a24a; rsp_err=0.
- Contention: req[0], req[2] high together, addrs 2 and 5 -> req0 served first (988b6a57...), then req2 (c3e0fed6...); grants 4 cycles apart; never multi-hot.
- Fairness: req[0] and req[3] held high continuously -> grants alternate 0,3,0,3; no starvation over 8 transactions.
- Out-of-range: req[2]=1, addr=7 -> mem_rd_en never asserts; rsp_valid=4'b0100 at N+2; rsp_data=0; rsp_err=1.
- Reset in WAIT: drop rst at N+2 -> gnt, rsp_valid, mem_rd_en = 0 immediately; no response pulse. Re-request after reset -> requester 0 has priority.
- With LC_ARB_TIMEOUT_EN: memory model forces mem_valid=0 -> rsp_err=1, rsp_data=0, rsp_valid pulsed 8 cycles after WAIT entry.
